// File: rtl/main_ctrl.sv
// Keypad command decoder: turns key press edges into one-cycle window/environment
// command pulses and holds the run/edit mode flag and the current view width.
module main_ctrl #(
  parameter int DEFAULT_WIDTH = 32,
  parameter int MIN_WIDTH     = 8,
  parameter int MAX_WIDTH     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keys,
  output logic [6:0]  win_ctrl_cmd,
  output logic [7:0]  envo_ctrl_cmd,
  output logic [7:0]  view_width,
  output logic        mode
);

  localparam logic [7:0] DEF_W = 8'(DEFAULT_WIDTH);
  localparam logic [7:0] MIN_W = 8'(MIN_WIDTH);
  localparam logic [7:0] MAX_W = 8'(MAX_WIDTH);

  logic [15:0] key_prev_q, key_prev_d;
  logic        mode_q, mode_d;
  logic [6:0]  win_q, win_d;
  logic [7:0]  envo_q, envo_d;
  logic [7:0]  width_q, width_d;
  logic [15:0] press;
  logic        edit;

  always_comb begin
    press      = keys & ~key_prev_q;
    edit       = ~mode_q;
    key_prev_d = keys;
    mode_d     = mode_q ^ press[10];
    width_d    = width_q;
    win_d      = '0;
    envo_d     = '0;

    win_d[3:0] = press[3:0];

    // Edit-only commands are gated by the mode held before this edge's toggle.
    if (edit) begin
      envo_d[3:0] = press[7:4];
      envo_d[4]   = press[8];
      envo_d[5]   = press[11];
      envo_d[6]   = press[9];
      envo_d[7]   = press[15];
    end

    if (press[14]) begin
      win_d[6] = 1'b1;
      width_d  = DEF_W;
    end else if (press[12] && !press[13]) begin
      win_d[4] = 1'b1;
      width_d  = (width_q > MIN_W) ? (width_q >> 1) : width_q;
    end else if (press[13] && !press[12]) begin
      win_d[5] = 1'b1;
      width_d  = (width_q < MAX_W) ? (width_q << 1) : width_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_prev_q <= keys;
      mode_q     <= 1'b0;
      win_q      <= '0;
      envo_q     <= '0;
      width_q    <= DEF_W;
    end else begin
      key_prev_q <= key_prev_d;
      mode_q     <= mode_d;
      win_q      <= win_d;
      envo_q     <= envo_d;
      width_q    <= width_d;
    end
  end

  assign win_ctrl_cmd  = win_q;
  assign envo_ctrl_cmd = envo_q;
  assign view_width    = width_q;
  assign mode          = mode_q;

endmodule

// File: tb/tb_main_ctrl.sv
// Bench for main_ctrl: directed scenarios then random key traffic, all checked
// against a behavioural keypad model.
module tb_main_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  logic [6:0]  win_ctrl_cmd;
  logic [7:0]  envo_ctrl_cmd;
  logic [7:0]  view_width;
  logic        mode;

  int vectors;
  int miscompares;

  // Reference model state
  logic [15:0] m_prev;
  bit          m_mode;
  logic [6:0]  m_win;
  logic [7:0]  m_envo;
  int          m_width;

  main_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .keys         (keys),
    .win_ctrl_cmd (win_ctrl_cmd),
    .envo_ctrl_cmd(envo_ctrl_cmd),
    .view_width   (view_width),
    .mode         (mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Keypad behaviour at one rising edge, written from the key map.
  task automatic model_edge(input logic [15:0] k, input logic r);
    logic [15:0] p;
    int edit_key [8];
    edit_key = '{4, 5, 6, 7, 8, 11, 9, 15};
    if (!r) begin
      m_prev  = k;
      m_mode  = 1'b0;
      m_win   = '0;
      m_envo  = '0;
      m_width = 32;
    end else begin
      p      = k & ~m_prev;
      m_prev = k;
      m_win  = '0;
      m_envo = '0;
      for (int i = 0; i < 4; i++) if (p[i]) m_win[i] = 1'b1;
      if (!m_mode)
        for (int j = 0; j < 8; j++) if (p[edit_key[j]]) m_envo[j] = 1'b1;
      if (p[14]) begin
        m_win[6] = 1'b1;
        m_width  = 32;
      end else if (p[12] && !p[13]) begin
        m_win[4] = 1'b1;
        m_width  = (m_width / 2 < 8) ? 8 : m_width / 2;
      end else if (p[13] && !p[12]) begin
        m_win[5] = 1'b1;
        m_width  = (m_width * 2 > 64) ? 64 : m_width * 2;
      end
      if (p[10]) m_mode = !m_mode;
    end
  endtask

  task automatic step(input logic [15:0] k, input logic r);
    @(negedge clk);
    keys = k;
    rst  = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
    check("win_ctrl_cmd", 32'(win_ctrl_cmd), 32'(m_win));
    check("envo_ctrl_cmd", 32'(envo_ctrl_cmd), 32'(m_envo));
    check("view_width", 32'(view_width), 32'(m_width));
    check("mode", 32'(mode), 32'(m_mode));
  endtask

  initial begin
    logic [15:0] cur;
    int          pulses;
    int          wexp [4];
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b0;
    keys = '0;

    // Reset
    repeat (3) step(16'h0000, 1'b0);
    check("reset_width", 32'(view_width), 32'd32);
    check("reset_mode", 32'(mode), 32'd0);

    // Mode toggle, with the key already held through reset
    step(16'h0400, 1'b0);
    step(16'h0400, 1'b1);
    check("held_through_reset_mode", 32'(mode), 32'd0);
    step(16'h0000, 1'b1);
    step(16'h0400, 1'b1);
    check("toggle_run", 32'(mode), 32'd1);
    step(16'h0400, 1'b1);
    check("toggle_held", 32'(mode), 32'd1);
    step(16'h0000, 1'b1);
    step(16'h0400, 1'b1);
    check("toggle_edit", 32'(mode), 32'd0);
    step(16'h0000, 1'b1);

    // Edit gating
    step(16'h0100, 1'b1);
    check("edit_toggle_pulse", 32'(envo_ctrl_cmd), 32'h10);
    step(16'h0000, 1'b1);
    check("edit_toggle_clear", 32'(envo_ctrl_cmd), 32'h0);
    step(16'h0400, 1'b1);
    step(16'h0000, 1'b1);
    step(16'h0100, 1'b1);
    check("run_gated", 32'(envo_ctrl_cmd), 32'h0);
    step(16'h0000, 1'b1);
    // Toggle plus edit command together: gated by the pre-toggle (run) mode
    step(16'h0500, 1'b1);
    check("toggle_plus_edit", 32'(envo_ctrl_cmd), 32'h0);
    check("toggle_plus_edit_mode", 32'(mode), 32'd0);
    step(16'h0000, 1'b1);

    // Zoom saturation
    wexp = '{16, 8, 8, 0};
    for (int i = 0; i < 3; i++) begin
      step(16'h1000, 1'b1);
      check("zoom_in_pulse", 32'(win_ctrl_cmd), 32'h10);
      check("zoom_in_width", 32'(view_width), 32'(wexp[i]));
      step(16'h0000, 1'b1);
    end
    wexp = '{16, 32, 64, 64};
    for (int i = 0; i < 4; i++) begin
      step(16'h2000, 1'b1);
      check("zoom_out_pulse", 32'(win_ctrl_cmd), 32'h20);
      check("zoom_out_width", 32'(view_width), 32'(wexp[i]));
      step(16'h0000, 1'b1);
    end

    // Simultaneous presses
    step(16'h3000, 1'b1);
    check("zin_zout_pulse", 32'(win_ctrl_cmd), 32'h0);
    check("zin_zout_width", 32'(view_width), 32'd64);
    step(16'h0000, 1'b1);
    step(16'h6000, 1'b1);
    check("home_zoom_pulse", 32'(win_ctrl_cmd), 32'h40);
    check("home_zoom_width", 32'(view_width), 32'd32);
    step(16'h0000, 1'b1);

    // Held key gives a single pulse
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(16'h0001, 1'b1);
      if (win_ctrl_cmd[0]) pulses++;
    end
    check("hold_single_pulse", 32'(pulses), 32'd1);
    step(16'h0000, 1'b1);

    // Pulse pending at a reset edge is cleared
    step(16'h000F, 1'b1);
    step(16'h0000, 1'b0);
    check("reset_clears_pulse", 32'(win_ctrl_cmd), 32'h0);

    // Random traffic with sparse key flips and occasional reset
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      cur = cur ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      step(cur, ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_ctrl.md
Name: main_ctrl

Overview:
- Top-level keypad command decoder for the Game-of-Life FPGA design.
- Samples a 16-key level vector and detects press events (rising edges).
- Converts presses into one-cycle command pulses for the display-window controller (win_ctrl_cmd) and the cell-environment controller (envo_ctrl_cmd).
- Holds the run/edit mode flag and the current view width (zoom level).

Parameters:
- DEFAULT_WIDTH, 32, view_width after reset and after the home command.
- MIN_WIDTH, 8, smallest view width (power of two).
- MAX_WIDTH, 64, largest view width (power of two).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- keys  input  16  keypad levels, 1 = held; already debounced/synchronised upstream.
- win_ctrl_cmd  output  7  one-hot-per-bit window command pulses.
- envo_ctrl_cmd  output  8  per-bit environment command pulses.
- view_width  output  8  current view width in cells.
- mode  output  1  0 = edit, 1 = run.

Behaviour:
- One clock, synchronous active-low reset: rst sampled low at a clk rising edge sets:
  - mode = 0
  - win_ctrl_cmd = 0
  - envo_ctrl_cmd = 0
  - view_width = DEFAULT_WIDTH
  - key_prev = keys (a key held through reset does not generate a press on release of reset)
- Press detection: press[i] = keys[i] & ~key_prev[i], evaluated at each edge; key_prev <= keys every non-reset edge.
- All outputs are registered. A press sampled at edge k produces its effect at edge k: the pulse is visible for exactly one cycle, then returns to 0. A held key gives one press only; a new press requires release for at least one sampled cycle.
- Gating uses the mode value before any same-edge toggle.
- Key map:
  - keys[0..3] -> win_ctrl_cmd[0..3]: pan up/down/left/right, both modes.
  - keys[4..7] -> envo_ctrl_cmd[0..3]: cursor up/down/left/right, edit mode only.
  - keys[8] -> envo_ctrl_cmd[4]: toggle cell at cursor, edit only.
  - keys[9] -> envo_ctrl_cmd[6]: single generation step, edit only.
  - keys[10]: toggle mode (mode <= ~mode); no pulse output.
  - keys[11] -> envo_ctrl_cmd[5]: clear all cells, edit only.
  - keys[12] -> win_ctrl_cmd[4]: zoom in; view_width halves, saturating at MIN_WIDTH.
  - keys[13] -> win_ctrl_cmd[5]: zoom out; view_width doubles, saturating at MAX_WIDTH.
  - keys[14] -> win_ctrl_cmd[6]: home; view_width <= DEFAULT_WIDTH.
  - keys[15] -> envo_ctrl_cmd[7]: load preset pattern, edit only.
- In run mode (mode = 1), edit-only presses are discarded (no pulse, not queued).
- Zoom pulses still fire when view_width is already saturated.
- Simultaneous presses:
  - Independent keys act together, so multiple output bits may pulse in the same cycle.
  - Zoom in + zoom out together: neither pulses, width unchanged.
  - Home has priority over zoom: home pulses, width = DEFAULT_WIDTH, zoom bits 0.
  - Mode toggle + edit command: the command is gated by the pre-toggle mode.
- Reset mid-operation: any pending pulse is cleared at the reset edge; mode and width return to reset values.
- view_width is always one of 8, 16, 32, 64 (for default parameters); upper bits are zero.

Test Plan:
- Reset: rst = 0 for 3 clocks with keys = 0 -> mode = 0, win_ctrl_cmd = 0, envo_ctrl_cmd = 0, view_width = 32.
- Mode toggle:
  - Release rst while keys[10] = 1 is first sampled high after reset, then release, then press again.
  - mode = 1 after the first press edge, held; mode = 0 after the second press.
  - A key already held during reset produces no toggle.
- Edit gating:
  - Press keys[8] with mode = 0 -> envo_ctrl_cmd = 8'h10 for exactly one cycle.
  - Same press with mode = 1 -> envo_ctrl_cmd stays 0.
- Zoom saturation:
  - From 32, press keys[12] three times -> view_width 16, 8, 8; win_ctrl_cmd = 7'h10 each press.
  - Press keys[13] four times -> 16, 32, 64, 64.
- Simultaneous:
  - keys[12] and keys[13] pressed together -> no win pulse, width unchanged.
  - keys[13] and keys[14] pressed together -> win_ctrl_cmd = 7'h40, width = 32.
- Hold: keys[0] held 10 cycles -> win_ctrl_cmd[0] high for exactly 1 cycle.
